wb_stage_mlane: RTL and testbench
=================================

# wb_stage_mlane

Parametrised writeback stage for the multi-issue LACPU pipeline. It accepts up to LANES retiring instructions per cycle from the memory stage. It drives one register-file write port and one forwarding bus per lane. Retirements are serialised in program order through an internal trace FIFO onto the single-entry debug trace port, because the trace comparator consumes one record per cycle. Backpressure to the memory stage is generated when the FIFO cannot absorb a full bundle.

## Interface
Parameters:
- LANES, 2: issue width, legal range 1..4; lane 0 is oldest.
- TRACE_DEPTH, 8: trace FIFO entries; power of 2, at least LANES.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- ws_allowin  out  1  stage can accept a bundle this cycle.
- ms_to_ws_valid  in  1  bundle valid.
- ms_lane_valid  in  LANES  per-lane valid mask; must be contiguous from lane 0.
- ms_to_ws_bus  in  LANES*70  lane i at [70i+69:70i] = {we, dest[4:0], result[31:0], pc[31:0]}.
- ws_to_rf_bus  out  LANES*38  lane i = {rf_we, rf_waddr[4:0], rf_wdata[31:0]}.
- ws_to_es_bus  out  LANES*38  lane i = {fwd_valid, fwd_dest[4:0], fwd_data[31:0]}.
- debug_wb_pc  out  32  trace pc.
- debug_wb_rf_wen  out  4  trace write enable, replicated.
- debug_wb_rf_wnum  out  5  trace destination.
- debug_wb_rf_wdata  out  32  trace data.
- trace_empty  out  1  trace FIFO empty.

## Operation
- Stage register: holds ws_valid, lane mask and bus. It is loaded when ms_to_ws_valid && ws_allowin. If ws_allowin is high and ms_to_ws_valid is low, ws_valid is cleared.
- n_act = popcount(lane mask held in the stage register).
- ws_ready_go = (TRACE_DEPTH − count) ≥ n_act, where count is the FIFO occupancy at the start of the cycle. A pop in the same cycle is not credited.
- ws_allowin = !ws_valid || ws_ready_go.
- fire = ws_valid && ws_ready_go. Every RF write and every FIFO push is qualified by fire, so each instruction writes exactly once even under stall.
- rf_we[i] = fire && lane_valid[i] && we[i] && dest[i]≠0 && no younger lane j>i with the same qualified write to dest[i]. Same-destination collision: the youngest lane wins and the older write is suppressed.
- Forwarding:
  - fwd_valid[i] = ws_valid && lane_valid[i] && we[i] && dest[i]≠0.
  - Forwarding is not gated by ws_ready_go, so a stalled stage still forwards.
  - Collision rule: same as the RF write rule.
- Trace FIFO:
  - On fire, push n_act entries {we&&dest≠0, dest, result, pc} in lane order.
  - Pop one entry per cycle whenever the FIFO is non-empty.
  - Push and pop may occur in the same cycle.
  - Pointers are log2(TRACE_DEPTH) bits and wrap modulo TRACE_DEPTH. Count is log2(TRACE_DEPTH)+1 bits.
- Debug outputs are driven combinationally from the FIFO head when it is non-empty. When the FIFO is empty, all four debug outputs are 0.
- Entries with we=0 still occupy one trace cycle, with wen=0.

## Timing
- Reset, which overrides everything: ws_valid=0, FIFO empty, trace_empty=1, all rf_we/fwd_valid=0, all debug outputs=0.
- Bundle accepted at edge t:
  - RF write and forwarding occur in cycle t+1 if ready_go.
  - Lane 0 appears on the debug port in cycle t+2.
  - Lane k appears in cycle t+2+k, plus any earlier backlog.
- Stall: the bundle is held, ws_allowin=0, and no RF write occurs. It fires in the first cycle where free slots ≥ n_act.
- Full FIFO: no push occurs. The pop continues, so the stall lasts at most n_act cycles after the backlog drains.
- Sustained throughput: bundles of n_act>1 continuously eventually backpressure to 1 instruction/cycle average.
- A reset asserted mid-stall discards the held bundle and the FIFO contents. No RF write occurs for it.

## Structure
- Shared mycpu.vh constants:
  - MS_TO_WS_LANE_WD=70
  - WS_TO_RF_LANE_WD=38
  - WS_TO_ES_LANE_WD=38
  - TRACE_ENT_WD=70
- Sub-module wb_trace_fifo: multi-push (up to LANES), single-pop circular buffer with count; parameters LANES and TRACE_DEPTH.
- Top level contains the stage register, popcount, the collision mask (generate loop) and the bus packing.

## Test plan
- LANES=2, single bundle with lane0 {we=1, dest=4, res=0x11, pc=0x1c000000} and lane1 {we=1, dest=5, res=0x22, pc=0x1c000004} -> cycle t+1 both rf_we=1. Debug port shows pc 0x1c000000 wen=0xf wnum=4 at t+2, then 0x1c000004 wnum=5 at t+3, then trace_empty=1.
- Same-dest collision: lane0 dest=7 res=0xA, lane1 dest=7 res=0xB -> only the lane1 RF write occurs. Both entries are traced in order.
- dest=0 with we=1 -> rf_we=0, fwd_valid=0, trace wen=0 with wnum=0 still emitted.
- TRACE_DEPTH=4, two-lane bundles every cycle -> ws_allowin drops once count>2. No bundle is lost or written twice. The trace pc sequence is strictly in program order across pointer wrap.
- Stall with the held bundle -> fwd_valid stays high, rf_we stays 0 until fire, then pulses for exactly one cycle.
- Reset asserted while stalled with 3 FIFO entries -> next cycle all outputs 0, trace_empty=1, ws_allowin=1.

Source files
------------

// File: rtl/wb_stage_mlane_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage_mlane_pkg
// Description : Shared widths and lane record layouts for the writeback stage.
// Revision    : 1.0
// ============================================================================
package wb_stage_mlane_pkg;

    localparam int MS_TO_WS_LANE_WD = 70;
    localparam int WS_TO_RF_LANE_WD = 38;
    localparam int WS_TO_ES_LANE_WD = 38;
    localparam int TRACE_ENT_WD     = 70;

    typedef struct packed {
        logic        we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } ms_lane_t;

    // Shared layout of a register-file write lane and a forwarding lane.
    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } ws_lane_t;

    typedef struct packed {
        logic        wen;
        logic [4:0]  wnum;
        logic [31:0] wdata;
        logic [31:0] pc;
    } trace_ent_t;

endpackage
`default_nettype wire

// File: rtl/wb_stage_mlane_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage_mlane_if
// Description : Memory-stage to writeback-stage bundle handshake.
// Revision    : 1.0
// ============================================================================
interface wb_stage_mlane_if
    import wb_stage_mlane_pkg::*;
#(
    parameter int LANES = 2
) ();

    logic                                ws_allowin;
    logic                                ms_to_ws_valid;
    logic [LANES-1:0]                    ms_lane_valid;
    logic [LANES*MS_TO_WS_LANE_WD-1:0]   ms_to_ws_bus;

    modport master (
        input  ws_allowin,
        output ms_to_ws_valid,
        output ms_lane_valid,
        output ms_to_ws_bus
    );

    modport slave (
        output ws_allowin,
        input  ms_to_ws_valid,
        input  ms_lane_valid,
        input  ms_to_ws_bus
    );

endinterface
`default_nettype wire

// File: rtl/wb_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_trace_fifo
// Description : Multi-push (up to LANES), single-pop circular trace buffer.
// Revision    : 1.0
// ============================================================================
module wb_trace_fifo
    import wb_stage_mlane_pkg::*;
#(
    parameter int LANES       = 2,
    parameter int TRACE_DEPTH = 8
) (
    input  wire logic                             clk,
    input  wire logic                             reset,
    input  wire logic [$clog2(TRACE_DEPTH):0]     push_cnt,
    input  wire logic [LANES*TRACE_ENT_WD-1:0]    push_data,
    output logic      [TRACE_ENT_WD-1:0]          head,
    output logic                                  empty,
    output logic      [$clog2(TRACE_DEPTH):0]     count
);

    localparam int C_PTR_W = $clog2(TRACE_DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;

    logic [TRACE_ENT_WD-1:0] r_mem [TRACE_DEPTH];
    logic [C_PTR_W-1:0]      r_wr_ptr;
    logic [C_PTR_W-1:0]      r_rd_ptr;
    logic [C_CNT_W-1:0]      r_count;
    logic                    w_pop;

    assign empty = (r_count == '0);
    assign w_pop = !empty;
    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

    // Pushed lanes are contiguous from lane 0, so entry k lands at wr_ptr+k.
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (C_CNT_W'(k) < push_cnt)
                r_mem[r_wr_ptr + C_PTR_W'(k)] <= push_data[k*TRACE_ENT_WD +: TRACE_ENT_WD];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + C_PTR_W'(push_cnt);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
            r_count  <= r_count + push_cnt - C_CNT_W'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_stage_mlane.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage_mlane
// Description : Multi-lane writeback stage with RF/forwarding buses and a
//               serialised debug trace port.
// Revision    : 1.0
// ============================================================================
module wb_stage_mlane
    import wb_stage_mlane_pkg::*;
#(
    parameter int LANES       = 2,
    parameter int TRACE_DEPTH = 8
) (
    input  wire logic                              clk,
    input  wire logic                              reset,
    wb_stage_mlane_if.slave                        ms,
    output logic [LANES*WS_TO_RF_LANE_WD-1:0]      ws_to_rf_bus,
    output logic [LANES*WS_TO_ES_LANE_WD-1:0]      ws_to_es_bus,
    output logic [31:0]                            debug_wb_pc,
    output logic [3:0]                             debug_wb_rf_wen,
    output logic [4:0]                             debug_wb_rf_wnum,
    output logic [31:0]                            debug_wb_rf_wdata,
    output logic                                   trace_empty
);

    localparam int C_CNT_W = $clog2(TRACE_DEPTH) + 1;

    logic                               r_ws_valid;
    logic [LANES-1:0]                   r_lane_valid;
    logic [LANES*MS_TO_WS_LANE_WD-1:0]  r_bus;

    logic [C_CNT_W-1:0]                 w_n_act;
    logic [C_CNT_W-1:0]                 w_count;
    logic [C_CNT_W-1:0]                 w_free;
    logic [C_CNT_W-1:0]                 w_push_cnt;
    logic                               w_ready_go;
    logic                               w_allowin;
    logic                               w_fire;
    logic [LANES-1:0]                   w_qual;
    logic [4:0]                         w_dest [LANES];
    logic [LANES*TRACE_ENT_WD-1:0]      w_push_data;
    trace_ent_t                         w_head;
    logic                               w_empty;

    assign w_free        = C_CNT_W'(TRACE_DEPTH) - w_count;
    assign w_ready_go    = (w_free >= w_n_act);
    assign w_allowin     = !r_ws_valid || w_ready_go;
    assign w_fire        = r_ws_valid && w_ready_go;
    assign w_push_cnt    = w_fire ? w_n_act : '0;
    assign ms.ws_allowin = w_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ws_valid   <= 1'b0;
            r_lane_valid <= '0;
            r_bus        <= '0;
        end else if (w_allowin) begin
            r_ws_valid <= ms.ms_to_ws_valid;
            if (ms.ms_to_ws_valid) begin
                r_lane_valid <= ms.ms_lane_valid;
                r_bus        <= ms.ms_to_ws_bus;
            end
        end
    end

    always_comb begin
        w_n_act = '0;
        for (int i = 0; i < LANES; i++)
            w_n_act = w_n_act + C_CNT_W'(r_lane_valid[i]);
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        ms_lane_t   w_lane;
        logic       w_kill;
        ws_lane_t   w_rf;
        ws_lane_t   w_fwd;
        trace_ent_t w_ent;

        assign w_lane    = r_bus[g*MS_TO_WS_LANE_WD +: MS_TO_WS_LANE_WD];
        assign w_dest[g] = w_lane.dest;
        assign w_qual[g] = r_lane_valid[g] && w_lane.we && (w_lane.dest != 5'd0);

        // A younger lane writing the same register makes this lane's write dead.
        always_comb begin
            w_kill = 1'b0;
            for (int j = g + 1; j < LANES; j++) begin
                if (w_qual[j] && (w_dest[j] == w_lane.dest))
                    w_kill = 1'b1;
            end
        end

        assign w_rf.we    = w_fire && w_qual[g] && !w_kill;
        assign w_rf.addr  = w_lane.dest;
        assign w_rf.data  = w_lane.result;
        assign w_fwd.we   = r_ws_valid && w_qual[g] && !w_kill;
        assign w_fwd.addr = w_lane.dest;
        assign w_fwd.data = w_lane.result;

        assign w_ent.wen   = w_lane.we && (w_lane.dest != 5'd0);
        assign w_ent.wnum  = w_lane.dest;
        assign w_ent.wdata = w_lane.result;
        assign w_ent.pc    = w_lane.pc;

        assign ws_to_rf_bus[g*WS_TO_RF_LANE_WD +: WS_TO_RF_LANE_WD] = w_rf;
        assign ws_to_es_bus[g*WS_TO_ES_LANE_WD +: WS_TO_ES_LANE_WD] = w_fwd;
        assign w_push_data[g*TRACE_ENT_WD +: TRACE_ENT_WD]          = w_ent;
    end

    wb_trace_fifo #(
        .LANES       (LANES),
        .TRACE_DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_cnt  (w_push_cnt),
        .push_data (w_push_data),
        .head      (w_head),
        .empty     (w_empty),
        .count     (w_count)
    );

    assign trace_empty       = w_empty;
    assign debug_wb_pc       = w_empty ? 32'd0 : w_head.pc;
    assign debug_wb_rf_wen   = w_empty ? 4'd0  : {4{w_head.wen}};
    assign debug_wb_rf_wnum  = w_empty ? 5'd0  : w_head.wnum;
    assign debug_wb_rf_wdata = w_empty ? 32'd0 : w_head.wdata;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage_mlane.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage_mlane
// Description : Scoreboard bench for the multi-lane writeback stage.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_wb_stage_mlane;

    localparam int LANES       = 2;
    localparam int TRACE_DEPTH = 4;

    logic                  clk   = 1'b0;
    logic                  reset = 1'b1;
    logic [LANES*38-1:0]   ws_to_rf_bus;
    logic [LANES*38-1:0]   ws_to_es_bus;
    logic [31:0]           debug_wb_pc;
    logic [3:0]            debug_wb_rf_wen;
    logic [4:0]            debug_wb_rf_wnum;
    logic [31:0]           debug_wb_rf_wdata;
    logic                  trace_empty;

    wb_stage_mlane_if #(.LANES(LANES)) ms_if ();

    wb_stage_mlane #(
        .LANES       (LANES),
        .TRACE_DEPTH (TRACE_DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .ms                (ms_if),
        .ws_to_rf_bus      (ws_to_rf_bus),
        .ws_to_es_bus      (ws_to_es_bus),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .trace_empty       (trace_empty)
    );

    always #5 clk = ~clk;

    wire [1:0] rf_we_v = {ws_to_rf_bus[75], ws_to_rf_bus[37]};
    wire [1:0] fwd_v   = {ws_to_es_bus[75], ws_to_es_bus[37]};

    typedef struct {
        int          lane;
        logic [4:0]  addr;
        logic [31:0] data;
    } rf_exp_t;

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  wen;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } tr_exp_t;

    rf_exp_t rf_q[$];
    tr_exp_t tr_q[$];
    rf_exp_t m_rf;
    tr_exp_t m_tr;
    int      n_checks = 0;
    int      n_pass   = 0;
    bit      mon_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Monitor: RF writes and trace records are matched against the queues.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (ws_to_rf_bus[38*i+37]) begin
                    if (rf_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL rf_spurious: lane %0d wrote r%0d, expected no write at %0t",
                                 i, ws_to_rf_bus[38*i+32 +: 5], $time);
                    end else begin
                        m_rf = rf_q.pop_front();
                        chk("rf_lane", i, m_rf.lane);
                        chk("rf_addr", {27'd0, ws_to_rf_bus[38*i+32 +: 5]}, {27'd0, m_rf.addr});
                        chk("rf_data", ws_to_rf_bus[38*i +: 32], m_rf.data);
                    end
                end
            end
            if (!trace_empty) begin
                if (tr_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL trace_spurious: got pc 0x%08h, expected no record at %0t",
                             debug_wb_pc, $time);
                end else begin
                    m_tr = tr_q.pop_front();
                    chk("trace_pc",    debug_wb_pc,                m_tr.pc);
                    chk("trace_wen",   {28'd0, debug_wb_rf_wen},   {28'd0, m_tr.wen});
                    chk("trace_wnum",  {27'd0, debug_wb_rf_wnum},  {27'd0, m_tr.wnum});
                    chk("trace_wdata", debug_wb_rf_wdata,          m_tr.wdata);
                end
            end else begin
                chk("trace_idle_zero",
                    debug_wb_pc | debug_wb_rf_wdata | {23'd0, debug_wb_rf_wnum, debug_wb_rf_wen}, 32'd0);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [1:0] mask, input logic [1:0] we,
                        input logic [4:0] d0, input logic [4:0] d1,
                        input logic [31:0] r0, input logic [31:0] r1,
                        input logic [31:0] p0, input logic [31:0] p1,
                        input logic [1:0] exp_rf, input logic [1:0] exp_twen,
                        input bit record, output int stalls);
        logic [4:0]  d [2];
        logic [31:0] r [2];
        logic [31:0] p [2];
        int n = 0;
        d[0] = d0; d[1] = d1; r[0] = r0; r[1] = r1; p[0] = p0; p[1] = p1;
        stalls = 0;
        ms_if.ms_to_ws_valid = 1'b1;
        ms_if.ms_lane_valid  = mask;
        ms_if.ms_to_ws_bus   = {we[1], d1, r1, p1, we[0], d0, r0, p0};
        while (!ms_if.ws_allowin && n < 20) begin
            @(negedge clk);
            n++;
            stalls++;
        end
        if (!ms_if.ws_allowin) begin
            n_checks++;
            $display("FAIL send_timeout: ws_allowin 0 for %0d cycles, required 1", n);
            ms_if.ms_to_ws_valid = 1'b0;
        end else begin
            @(posedge clk);
            if (record) begin
                for (int i = 0; i < LANES; i++) begin
                    if (mask[i]) begin
                        if (exp_rf[i]) rf_q.push_back('{i, d[i], r[i]});
                        tr_q.push_back('{p[i], {4{exp_twen[i]}}, d[i], r[i]});
                    end
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic idle();
        ms_if.ms_to_ws_valid = 1'b0;
        ms_if.ms_lane_valid  = '0;
    endtask

    task automatic wait_drain();
        int n = 0;
        int quiet = 0;
        while (quiet < 3 && n < 80) begin
            @(negedge clk);
            n++;
            quiet = trace_empty ? quiet + 1 : 0;
        end
        if (quiet < 3) begin
            n_checks++;
            $display("FAIL drain_timeout: trace_empty still 0 after %0d cycles, required 1", n);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int tot;
        ms_if.ms_to_ws_valid = 1'b0;
        ms_if.ms_lane_valid  = '0;
        ms_if.ms_to_ws_bus   = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_allowin",     {31'd0, ms_if.ws_allowin}, 32'd1);
        chk("rst_trace_empty", {31'd0, trace_empty},      32'd1);
        chk("rst_rf_bus",      {31'd0, |ws_to_rf_bus},    32'd0);
        chk("rst_es_bus",      {31'd0, |ws_to_es_bus},    32'd0);
        chk("rst_debug",       debug_wb_pc | debug_wb_rf_wdata, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        mon_en = 1'b1;
        @(negedge clk);

        // Two independent lanes: timing of RF write and trace records.
        send(2'b11, 2'b11, 5'd4, 5'd5, 32'h11, 32'h22, 32'h1c000000, 32'h1c000004,
             2'b11, 2'b11, 1'b1, st);
        idle();
        chk("t1_rf_we",      {30'd0, rf_we_v},      32'd3);
        chk("t1_trace_t1",   {31'd0, trace_empty},  32'd1);
        @(negedge clk);
        chk("t1_pc_t2",      debug_wb_pc,           32'h1c000000);
        chk("t1_wen_t2",     {28'd0, debug_wb_rf_wen},  32'hf);
        chk("t1_wnum_t2",    {27'd0, debug_wb_rf_wnum}, 32'd4);
        @(negedge clk);
        chk("t1_pc_t3",      debug_wb_pc,           32'h1c000004);
        chk("t1_wnum_t3",    {27'd0, debug_wb_rf_wnum}, 32'd5);
        @(negedge clk);
        chk("t1_empty_t4",   {31'd0, trace_empty},  32'd1);
        wait_drain();

        // Same-destination collision: only the younger lane writes.
        send(2'b11, 2'b11, 5'd7, 5'd7, 32'hA, 32'hB, 32'h1c000008, 32'h1c00000c,
             2'b10, 2'b11, 1'b1, st);
        idle();
        chk("t2_rf_we",      {30'd0, rf_we_v},          32'd2);
        chk("t2_rf1_data",   ws_to_rf_bus[38 +: 32],    32'hB);
        chk("t2_fwd",        {30'd0, fwd_v},            32'd2);
        wait_drain();

        // dest=0 with we=1, and we=0: no writes, traced with wen=0.
        send(2'b11, 2'b01, 5'd0, 5'd3, 32'h33, 32'h44, 32'h1c000010, 32'h1c000014,
             2'b00, 2'b00, 1'b1, st);
        idle();
        chk("t3_rf_we",      {30'd0, rf_we_v},  32'd0);
        chk("t3_fwd",        {30'd0, fwd_v},    32'd0);
        wait_drain();

        // Single-lane bundle; the invalid lane must not suppress lane 0.
        send(2'b01, 2'b11, 5'd9, 5'd9, 32'h55, 32'h66, 32'h1c000018, 32'hdeadbeef,
             2'b01, 2'b01, 1'b1, st);
        idle();
        chk("t4_rf_we",      {30'd0, rf_we_v},  32'd1);
        wait_drain();

        // Back-to-back two-lane bundles into a 4-entry trace FIFO.
        tot = 0;
        for (int b = 0; b < 6; b++) begin
            send(2'b11, 2'b11, 5'(2*b+1), 5'(2*b+2), 32'h100 + 32'(2*b), 32'h101 + 32'(2*b),
                 32'h1c000100 + 32'(8*b), 32'h1c000104 + 32'(8*b), 2'b11, 2'b11, 1'b1, st);
            tot += st;
        end
        idle();
        chk("tput_backpressure", {31'd0, tot > 0}, 32'd1);
        wait_drain();

        // Stall: the held bundle forwards, then writes for exactly one cycle.
        send(2'b11, 2'b11, 5'd13, 5'd14, 32'h200, 32'h201, 32'h1c000200, 32'h1c000204, 2'b11, 2'b11, 1'b1, st);
        send(2'b11, 2'b11, 5'd15, 5'd16, 32'h202, 32'h203, 32'h1c000208, 32'h1c00020c, 2'b11, 2'b11, 1'b1, st);
        send(2'b11, 2'b11, 5'd17, 5'd18, 32'h204, 32'h205, 32'h1c000210, 32'h1c000214, 2'b11, 2'b11, 1'b1, st);
        idle();
        chk("stall_allowin", {31'd0, ms_if.ws_allowin}, 32'd0);
        chk("stall_fwd",     {30'd0, fwd_v},            32'd3);
        chk("stall_fwd1",    ws_to_es_bus[38 +: 32],    32'h205);
        chk("stall_rf_we",   {30'd0, rf_we_v},          32'd0);
        @(negedge clk);
        chk("fire_rf_we",    {30'd0, rf_we_v},          32'd3);
        @(negedge clk);
        chk("after_rf_we",   {30'd0, rf_we_v},          32'd0);
        wait_drain();

        // Reset while stalled with three trace entries pending.
        @(posedge clk);
        mon_en = 1'b0;
        @(negedge clk);
        send(2'b11, 2'b11, 5'd20, 5'd21, 32'h300, 32'h301, 32'h1c000300, 32'h1c000304, 2'b11, 2'b11, 1'b0, st);
        send(2'b11, 2'b11, 5'd22, 5'd23, 32'h302, 32'h303, 32'h1c000308, 32'h1c00030c, 2'b11, 2'b11, 1'b0, st);
        send(2'b11, 2'b11, 5'd24, 5'd25, 32'h304, 32'h305, 32'h1c000310, 32'h1c000314, 2'b11, 2'b11, 1'b0, st);
        chk("rst2_stalled",    {31'd0, ms_if.ws_allowin}, 32'd0);
        chk("rst2_nonempty",   {31'd0, trace_empty},      32'd0);
        reset = 1'b1;
        idle();
        @(negedge clk);
        chk("rst2_allowin",    {31'd0, ms_if.ws_allowin}, 32'd1);
        chk("rst2_empty",      {31'd0, trace_empty},      32'd1);
        chk("rst2_rf_bus",     {31'd0, |ws_to_rf_bus},    32'd0);
        chk("rst2_es_bus",     {31'd0, |ws_to_es_bus},    32'd0);
        chk("rst2_debug",      debug_wb_pc | debug_wb_rf_wdata | {23'd0, debug_wb_rf_wnum, debug_wb_rf_wen}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst2_no_write",   {30'd0, rf_we_v},          32'd0);
        chk("rst2_still_empty",{31'd0, trace_empty},      32'd1);
        @(posedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        wait_drain();

        chk("rf_queue_empty",    rf_q.size(), 32'd0);
        chk("trace_queue_empty", tr_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
